// File: rtl/kb_sync_filter.sv
// Multi-channel pin conditioner: synchroniser chain, stability filter, rise/fall
// pulse generation and a saturating per-channel glitch counter.
module kb_sync_filter #(
    parameter int                NUM_CH      = 2,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILTER_LEN  = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL   = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     async_in,
    input  logic                  cnt_clr,
    output logic [NUM_CH-1:0]     sync_out,
    output logic [NUM_CH-1:0]     filt_out,
    output logic [NUM_CH-1:0]     rise_pulse,
    output logic [NUM_CH-1:0]     fall_pulse,
    output logic [NUM_CH*8-1:0]   glitch_cnt
);

    localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // chain[0] is the only flop fed asynchronously; the whole chain is
        // kept together so placement treats it as one metastability group.
        (* async_reg = "true" *) logic [SYNC_STAGES-1:0] chain;
        logic          sync_bit;
        logic          filt;
        logic          rise;
        logic          fall;
        logic [CW-1:0] cnt;
        logic [7:0]    gcnt;
        logic          mismatch;
        logic          glitch;

        assign sync_bit = chain[SYNC_STAGES-1];
        assign mismatch = (sync_bit != filt);
        assign glitch   = !mismatch && (cnt != '0);

        // NOTE: all state updates use <= so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                chain <= {SYNC_STAGES{RESET_VAL[i]}};
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], async_in[i]};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                filt <= RESET_VAL[i];
                cnt  <= '0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                if (mismatch) begin
                    if (cnt == CNT_MAX) begin
                        filt <= sync_bit;
                        cnt  <= '0;
                        rise <= sync_bit;
                        fall <= ~sync_bit;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else if (glitch) begin
                    cnt <= '0;
                end
            end
        end

        // A clear coinciding with a completed glitch leaves the count at zero.
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                gcnt <= '0;
            end else if (glitch && gcnt != 8'hFF) begin
                gcnt <= gcnt + 8'd1;
            end
        end

        assign sync_out[i]         = sync_bit;
        assign filt_out[i]         = filt;
        assign rise_pulse[i]       = rise;
        assign fall_pulse[i]       = fall;
        assign glitch_cnt[8*i +: 8] = gcnt;
    end

endmodule

// File: tb/tb_kb_sync_filter.sv
// Self-checking bench for kb_sync_filter: directed scenarios plus random pin
// activity, compared each cycle against a history-based reference model.
module tb_kb_sync_filter;

    localparam int                NUM_CH = 2;
    localparam int                SS     = 2;
    localparam int                FL     = 4;
    localparam int                HL     = (FL > 2) ? FL : 2;
    localparam logic [NUM_CH-1:0] RV     = '1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_CH-1:0]   async_in = '0;
    logic                cnt_clr = 1'b0;

    logic [NUM_CH-1:0]   sync_out, filt_out, rise_pulse, fall_pulse;
    logic [NUM_CH*8-1:0] glitch_cnt;
    logic [NUM_CH-1:0]   sync1, filt1, rise1, fall1;
    logic [NUM_CH*8-1:0] glitch1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    kb_sync_filter #(.NUM_CH(NUM_CH), .SYNC_STAGES(SS), .FILTER_LEN(FL), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .async_in(async_in), .cnt_clr(cnt_clr),
        .sync_out(sync_out), .filt_out(filt_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .glitch_cnt(glitch_cnt)
    );

    kb_sync_filter #(.NUM_CH(NUM_CH), .SYNC_STAGES(SS), .FILTER_LEN(1), .RESET_VAL(RV)) dut_nf (
        .clk(clk), .rst(rst), .async_in(async_in), .cnt_clr(cnt_clr),
        .sync_out(sync1), .filt_out(filt1), .rise_pulse(rise1),
        .fall_pulse(fall1), .glitch_cnt(glitch1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference state: async samples (newest at back) and the pre-edge
    // synchronised values the filter has seen (newest at back).
    logic [NUM_CH-1:0] ah[$];
    logic [NUM_CH-1:0] hist[$];
    logic [NUM_CH-1:0] m_sync, m_filt, m_rise, m_fall;
    logic [7:0]        m_gcnt [NUM_CH];
    logic [NUM_CH-1:0] m_filt1, m_rise1, m_fall1;
    int n_rise0 = 0, n_fall0 = 0;

    task automatic tick();
        logic [NUM_CH-1:0] pre;
        logic              accept, glitch;
        if (rst) begin
            ah.delete();
            hist.delete();
            for (int k = 0; k <= SS; k++) ah.push_back(RV);
            for (int k = 0; k < HL; k++)  hist.push_back(RV);
            m_filt = RV; m_rise = '0; m_fall = '0;
            m_filt1 = RV; m_rise1 = '0; m_fall1 = '0;
            for (int c = 0; c < NUM_CH; c++) m_gcnt[c] = 8'd0;
        end else begin
            ah.push_back(async_in);
            void'(ah.pop_front());
            pre = ah[0];                 // sample taken SS edges ago
            hist.push_back(pre);
            void'(hist.pop_front());
            for (int c = 0; c < NUM_CH; c++) begin
                accept = 1'b1;
                for (int j = 0; j < FL; j++)
                    if (hist[HL-1-j][c] == m_filt[c]) accept = 1'b0;
                glitch = (hist[HL-1][c] == m_filt[c]) && (hist[HL-2][c] != m_filt[c]);
                m_rise[c] = accept && pre[c];
                m_fall[c] = accept && !pre[c];
                if (accept) m_filt[c] = pre[c];
                if (cnt_clr) m_gcnt[c] = 8'd0;
                else if (glitch && m_gcnt[c] != 8'd255) m_gcnt[c] = m_gcnt[c] + 8'd1;
            end
            m_rise1 = pre & ~m_filt1;
            m_fall1 = ~pre & m_filt1;
            m_filt1 = pre;
        end
        m_sync = ah[1];
        @(posedge clk);
        #1;
        check("sync_out", sync_out, m_sync);
        check("filt_out", filt_out, m_filt);
        check("rise_pulse", rise_pulse, m_rise);
        check("fall_pulse", fall_pulse, m_fall);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("glitch_cnt%0d", c), glitch_cnt[8*c +: 8], m_gcnt[c]);
        check("nf_filt_out", filt1, m_filt1);
        check("nf_rise_pulse", rise1, m_rise1);
        check("nf_fall_pulse", fall1, m_fall1);
        check("nf_glitch_cnt", glitch1, '0);
        n_rise0 += int'(rise_pulse[0]);
        n_fall0 += int'(fall_pulse[0]);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // NOTE: stimulus is driven with blocking assignments #1 after the edge.
    initial begin
        // Reset with pins low: outputs sit at RESET_VAL.
        rst = 1'b1; async_in = 2'b00;
        run(3);
        check("rst_sync", sync_out, 2'b11);
        check("rst_filt", filt_out, 2'b11);
        check("rst_pulses", {rise_pulse, fall_pulse}, 4'b0);
        check("rst_gcnt", glitch_cnt, 16'd0);

        // Release: fall appears exactly SS+FL edges later.
        rst = 1'b0;
        for (int k = 1; k < SS + FL; k++) begin
            tick();
            check("rel_wait_filt", filt_out[0], 1'b1);
        end
        tick();
        check("rel_fall", fall_pulse[0], 1'b1);
        check("rel_filt", filt_out[0], 1'b0);
        async_in = 2'b11;
        run(20);

        // Clean transition on channel 0.
        n_fall0 = 0;
        async_in[0] = 1'b0;
        run(20);
        check("clean_fall_count", n_fall0, 1);
        check("clean_gcnt0", glitch_cnt[7:0], 8'd0);
        check("clean_ch1", filt_out[1], 1'b1);
        async_in[0] = 1'b1;
        run(12);

        // Glitches on channel 1, then saturation.
        async_in[1] = 1'b0; run(3);
        async_in[1] = 1'b1; run(6);
        check("glitch_one", glitch_cnt[15:8], 8'd1);
        check("glitch_filt", filt_out[1], 1'b1);
        for (int r = 0; r < 300; r++) begin
            async_in[1] = 1'b0; run(3);
            async_in[1] = 1'b1; run(2);
        end
        run(4);
        check("glitch_sat", glitch_cnt[15:8], 8'd255);

        // Clear on the very edge a glitch completes.
        async_in[1] = 1'b0; run(3);
        async_in[1] = 1'b1; run(2);
        check("clr_pre", glitch_cnt[15:8], 8'd255);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check("clr_collision", glitch_cnt[15:8], 8'd0);
        run(4);

        // Boundary: exactly FL cycles low is accepted, then FL high again.
        n_rise0 = 0; n_fall0 = 0;
        async_in[0] = 1'b0; run(FL);
        async_in[0] = 1'b1; run(FL + 8);
        check("bound_fall", n_fall0, 1);
        check("bound_rise", n_rise0, 1);
        check("bound_filt", filt_out[0], 1'b1);

        // Reset while a falling transition is pending (cnt = 2).
        n_fall0 = 0;
        async_in[0] = 1'b0; run(SS + 2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_filt", filt_out[0], 1'b1);
        check("midrst_nofall", n_fall0, 0);
        async_in[0] = 1'b1; run(10);

        // Random pin activity with occasional clears and resets.
        for (int k = 0; k < 2500; k++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(5) == 0) async_in[c] = ~async_in[c];
            cnt_clr = ($urandom_range(49) == 0);
            rst     = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0; cnt_clr = 1'b0;
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
